// File: rtl/rf_alu_seq_pkg.sv
// Shared encodings for the register-file/ALU command sequencer.
package rf_alu_seq_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ALU  = 2'b01,
    OP_NOP  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // ALU function codes passed through to the datapath
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_AND = 3'b011
  } aluc_e;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // Command fields captured at the accept edge
  typedef struct packed {
    op_e         op;
    logic [2:0]  aluc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [31:0] imm;
  } cmd_t;

endpackage

// File: rtl/rf_alu_seq.sv
// Command sequencer driving an external register file + ALU datapath.
// LOAD/NOP retire one cycle after accept, ALU two cycles after accept.
module rf_alu_seq
  import rf_alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_aluc,
  input  logic [4:0]  cmd_ra,
  input  logic [4:0]  cmd_rb,
  input  logic [4:0]  cmd_rw,
  input  logic [31:0] cmd_imm,
  output logic        we,
  output logic        mux3,
  output logic [2:0]  aluc,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [4:0]  rw,
  output logic [31:0] rd,
  input  logic [31:0] alu_out,
  input  logic        zero,
  output logic        done,
  output logic [31:0] res,
  output logic        res_zero,
  output logic        busy,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  cmd_t        cmd_q;
  logic [31:0] res_q;
  logic        res_zero_q;
  logic [15:0] retired_q;
  logic        accept;

  // Ready is held low while reset is asserted so nothing is accepted then
  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;

  // State register; reset drops straight to IDLE so in-flight work is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: ALU takes EXEC+WB, everything else a single LOAD slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (op_e'(cmd_op) == OP_ALU) ? S_EXEC : S_LOAD;
      S_LOAD: state_d = S_IDLE;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command capture only on accept; busy-time offers are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmd_q <= '0;
    else if (accept) cmd_q <= '{op: op_e'(cmd_op), aluc: cmd_aluc, ra: cmd_ra,
                                rb: cmd_rb, rw: cmd_rw, imm: cmd_imm};
  end

  // Datapath controls decoded purely from state; writes to R0 are dropped
  always_comb begin
    we   = 1'b0;
    mux3 = 1'b0;
    aluc = '0;
    ra   = '0;
    rb   = '0;
    rw   = '0;
    rd   = '0;
    done = 1'b0;
    case (state_q)
      S_LOAD: begin
        done = 1'b1;
        if (cmd_q.op == OP_LOAD) begin
          rw = cmd_q.rw;
          rd = cmd_q.imm;
          we = |cmd_q.rw;
        end
      end
      S_EXEC: begin
        ra   = cmd_q.ra;
        rb   = cmd_q.rb;
        aluc = cmd_q.aluc;
      end
      S_WB: begin
        ra   = cmd_q.ra;
        rb   = cmd_q.rb;
        aluc = cmd_q.aluc;
        rw   = cmd_q.rw;
        mux3 = 1'b1;
        we   = |cmd_q.rw;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result capture at ALU retirement only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q      <= '0;
      res_zero_q <= 1'b0;
    end else if (state_q == S_WB) begin
      res_q      <= alu_out;
      res_zero_q <= zero;
    end
  end

  // Retirement counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       retired_q <= '0;
    else if (done) retired_q <= retired_q + 16'd1;
  end

  assign res      = res_q;
  assign res_zero = res_zero_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_rf_alu_seq.sv
// Bench: behavioural register file + ALU beside the sequencer, with a
// command-level reference model for register contents, results and counts.
module tb_rf_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_aluc;
  logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
  logic [31:0] cmd_imm;
  logic        we, mux3, done, res_zero, busy, zero;
  logic [2:0]  aluc;
  logic [4:0]  ra, rb, rw;
  logic [31:0] rd, alu_out, res;
  logic [15:0] retired;

  rf_alu_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_aluc(cmd_aluc), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rw(cmd_rw), .cmd_imm(cmd_imm), .we(we), .mux3(mux3), .aluc(aluc),
    .ra(ra), .rb(rb), .rw(rw), .rd(rd), .alu_out(alu_out), .zero(zero),
    .done(done), .res(res), .res_zero(res_zero), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 + 32'(i * 3);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural datapath
  logic        tb_init;
  logic [31:0] rf [32];
  always_comb alu_out = alu_ref(aluc, rf[ra], rf[rb]);
  assign zero = (alu_out == 32'h0);
  always @(posedge clk) begin
    if (tb_init) for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
    else if (we) rf[rw] <= mux3 ? alu_out : rd;
  end

  // Protocol monitor
  int   acc_cnt = 0, done_cnt = 0, we_cnt = 0, mon_viol = 0;
  logic done_prev = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (we) we_cnt <= we_cnt + 1;
      if ((done && done_prev) || (we && rw == 5'd0) || (busy !== ~cmd_ready))
        mon_viol <= mon_viol + 1;
    end
    done_prev <= done;
  end

  // Reference model state
  logic [31:0] exp_rf [32];
  logic [31:0] exp_res;
  logic        exp_zero;
  logic [15:0] exp_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [2:0] f, input logic [4:0] a,
                             input logic [4:0] b, input logic [4:0] w, input logic [31:0] imm);
    logic [31:0] r;
    if (op == 2'b00) begin
      if (w != 0) exp_rf[w] = imm;
    end else if (op == 2'b01) begin
      r = alu_ref(f, exp_rf[a], exp_rf[b]);
      if (w != 0) exp_rf[w] = r;
      exp_res  = r;
      exp_zero = (r == 32'h0);
    end
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic chk_rf(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 32'({we, mux3, aluc, ra, rb, rw, done}), 32'd0);
    chk({tag, "_rd"}, rd, 32'd0);
  endtask

  // One complete command: offer, accept, latency and phase checks, retire checks
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] w, input logic [31:0] imm);
    int n, lat;
    logic is_alu, exp_we;
    is_alu = (op == 2'b01);
    exp_we = (op == 2'b00 || is_alu) && (w != 0);
    cmd_op = op; cmd_aluc = f; cmd_ra = a; cmd_rb = b; cmd_rw = w; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (is_alu) begin
      chk("exec_ctl", 32'({ra, rb, aluc, we, done}), 32'({a, b, f, 1'b0, 1'b0}));
    end
    lat = 1;
    while (!done && lat < 6) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), is_alu ? 32'd2 : 32'd1);
    chk("ret_we", 32'({we, mux3}), 32'({exp_we, is_alu}));
    if (exp_we) chk("ret_rw", 32'(rw), 32'(w));
    if (is_alu) chk("wb_src", 32'({ra, rb, aluc}), 32'({a, b, f}));
    model_apply(op, f, a, b, w, imm);
    @(posedge clk);
    #1;
    chk_rf("rf");
    chk("res", res, exp_res);
    chk("res_zero", 32'(res_zero), 32'(exp_zero));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk_idle("idle_outs");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, d0, w0;
    logic [1:0] op;
    rst = 1'b1; tb_init = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_aluc = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_imm = '0;
    for (int i = 0; i < 32; i++) exp_rf[i] = init_val(i);
    exp_res = '0; exp_zero = 1'b0; exp_ret = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk_idle("rst_outs");
    chk("rst_res", 32'({res, res_zero}), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    rst = 1'b0; tb_init = 1'b0;
    #1 chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Two loads then the ALU operations
    do_cmd(2'b00, 3'd0, 5'd0, 5'd0, 5'd4, 32'h04);
    do_cmd(2'b00, 3'd0, 5'd0, 5'd0, 5'd5, 32'h05);
    chk("R4", rf[4], 32'h04);
    chk("R5", rf[5], 32'h05);
    chk("retired_2", 32'(retired), 32'd2);
    do_cmd(2'b01, 3'd0, 5'd4, 5'd5, 5'd6, 32'h0);
    chk("R6_add", rf[6], 32'h09);
    chk("res_add", res, 32'h09);
    do_cmd(2'b01, 3'd1, 5'd4, 5'd5, 5'd7, 32'h0);
    chk("res_sub", res, 32'hFFFF_FFFF);
    chk("R7_sub", rf[7], 32'hFFFF_FFFF);
    do_cmd(2'b01, 3'd2, 5'd4, 5'd5, 5'd8, 32'h0);
    chk("res_or", res, 32'h05);
    do_cmd(2'b01, 3'd3, 5'd4, 5'd5, 5'd9, 32'h0);
    chk("res_and", res, 32'h04);
    do_cmd(2'b01, 3'd1, 5'd4, 5'd4, 5'd10, 32'h0);
    chk("res_zero_sub", 32'({res_zero, res == 32'h0}), 32'b11);

    // Suppressed writes: LOAD to R0, NOP, reserved op, ALU into R0
    w0 = we_cnt;
    do_cmd(2'b00, 3'd0, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF);
    do_cmd(2'b10, 3'd0, 5'd1, 5'd2, 5'd3, 32'h1234_5678);
    do_cmd(2'b11, 3'd0, 5'd1, 5'd2, 5'd3, 32'h1234_5678);
    chk("we_suppressed", 32'(we_cnt - w0), 32'd0);
    do_cmd(2'b01, 3'd0, 5'd4, 5'd5, 5'd0, 32'h0);
    chk("R0_kept", rf[0], init_val(0));

    // cmd_valid held high across several back-to-back commands
    @(negedge clk);
    a0 = acc_cnt; d0 = done_cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 1) ? 2'b01 : 2'b00;
      cmd_op = op; cmd_aluc = 3'(i % 4); cmd_ra = 5'd11 + 5'(i / 2); cmd_rb = 5'd4;
      cmd_rw = 5'd11 + 5'(i); cmd_imm = $urandom;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      chk("held_wait", 32'(n < 20), 32'd1);
      @(posedge clk);
      model_apply(op, cmd_aluc, cmd_ra, cmd_rb, cmd_rw, cmd_imm);
      @(negedge clk);
      chk("held_busy", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("held_accepts", 32'(acc_cnt - a0), 32'd6);
    chk("held_dones", 32'(done_cnt - d0), 32'd6);
    chk_rf("held_rf");
    chk("held_retired", 32'(retired), 32'(exp_ret));

    // Reset while an ALU command sits in EXEC
    cmd_op = 2'b01; cmd_aluc = 3'd0; cmd_ra = 5'd4; cmd_rb = 5'd5; cmd_rw = 5'd20;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_exec", 32'({ra, rb}), 32'({5'd4, 5'd5}));
    rst = 1'b1;
    #1;
    chk("rst_we_done", 32'({we, done}), 32'd0);
    chk_idle("rst_mid_outs");
    chk("rst_mid_regs", 32'({res_zero, retired}), 32'd0);
    chk("rst_mid_res", res, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0; exp_res = '0; exp_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("R20_untouched", rf[20], exp_rf[20]);
    do_cmd(2'b01, 3'd0, 5'd4, 5'd5, 5'd20, 32'h0);
    chk("post_rst_retired", 32'(retired), 32'd1);

    // Randomised command stream against the reference model
    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
    end

    @(negedge clk);
    chk("monitor", 32'(mon_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_alu_seq.md
RF_ALU_SEQ -- requirements
Module: rf_alu_seq

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 LOAD, 01 ALU, 10 NOP, 11 reserved
- cmd_aluc  in  3  ALU function: 000 add, 001 sub, 010 or, 011 and
- cmd_ra, cmd_rb, cmd_rw  in  5 each  source and destination register indices
- cmd_imm  in  32  immediate for LOAD
- we  out  1  register-file write enable
- mux3  out  1  write-data select: 0 = rd, 1 = alu_out
- aluc  out  3  ALU function to datapath
- ra, rb, rw  out  5 each  datapath read and write addresses
- rd  out  32  immediate write data
- alu_out  in  32  datapath ALU result
- zero  in  1  datapath ALU zero flag
- done  out  1  one-cycle pulse when a command retires
- res  out  32  last ALU result captured
- res_zero  out  1  zero flag captured with res
- busy  out  1  equals ~cmd_ready
- retired  out  16  count of retired commands

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, EXEC and WB.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready, and all cmd_* fields are registered at that edge.
REQ-005 Accepted LOAD SHALL go IDLE->LOAD; in LOAD: we=1, mux3=0, rw=cmd_rw, rd=cmd_imm; done=1; the next state is IDLE.
REQ-006 Accepted ALU SHALL go IDLE->EXEC->WB->IDLE.
- EXEC: ra/rb/aluc driven, we=0.
- WB: ra/rb/aluc held, rw=cmd_rw, mux3=1, we=1, done=1; res<=alu_out and res_zero<=zero at the WB->IDLE edge.
REQ-007 Accepted NOP or reserved op SHALL go IDLE->LOAD with we forced 0; it retires with done=1.
REQ-008 Any write with rw==0 SHALL be suppressed (we=0); the command still retires and pulses done.
REQ-009 Latency from the accept edge SHALL be 1 cycle to done for LOAD/NOP and 2 cycles for ALU; peak throughput is one LOAD per 2 cycles and one ALU per 3 cycles.
REQ-010 In IDLE, outputs SHALL be we=0, mux3=0, aluc=0, ra=rb=rw=0, rd=0, done=0.
REQ-011 done SHALL never be high for two consecutive cycles.
REQ-012 cmd_valid while busy SHALL be ignored and SHALL not be captured.
REQ-013 retired SHALL increment by 1 on every done and wrap from 16'hFFFF to 0.
REQ-014 res and res_zero SHALL change only at ALU retirement.

Reset
REQ-015 rst high SHALL immediately force IDLE with every output 0, including res, res_zero and retired; cmd_ready becomes 1 once rst is low.
REQ-016 A command in flight at reset SHALL be discarded without write or done; we must drop in the same cycle rst rises.

Structure
REQ-017 The package rf_alu_seq_pkg SHALL hold the op encodings, the ALU function codes and the state enum.
REQ-018 The block SHALL be a single module with no sub-module; the datapath (register file + ALU) is instantiated beside it, not inside it.

Verification
REQ-019 The bench SHALL connect a behavioural register file + ALU model and cover the following directed scenarios:
- LOAD rw=4 imm=04H, then LOAD rw=5 imm=05H -> each gives one done; R4=04H, R5=05H; retired=2.
- ALU add ra=4 rb=5 rw=6 -> done 2 cycles after accept; R6=09H, res=09H, res_zero=0.
- ALU sub R4-R5 -> R7 and res = FFFFFFFFH; ALU or -> 05H; ALU and -> 04H; sub R4-R4 -> res_zero=1.
- LOAD rw=0 imm=DEADBEEFH and a NOP -> we never high; done pulses; R0 unchanged.
- cmd_valid held high continuously -> cmd_ready low during LOAD/EXEC/WB; no command lost or duplicated; done never back-to-back.
- rst asserted during EXEC -> outputs 0 at once; no write to rw; retired=0; next command executes normally.
